// File: rtl/exception_sequencer.sv
// exception_sequencer: prioritises exception requests and drives the 4-cycle ARM-style entry sequence, passing core writeback through when idle
//   in : clk, rst (sync, active-high), cpsr_in, exc_pc, req[5:0] (und,svc,pabt,dabt,irq,fiq),
//        core_w_addr, core_w_data, core_write_reg, core_write_pc, core_pc_data
//   out: M, w_addr, w_data, write_reg, write_pc, pc_data, spsr_we, spsr_mode, spsr_data,
//        cpsr_we, cpsr_data, exc_ack, stall, exc_done
module exception_sequencer #(
  parameter logic [31:0] VBASE = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] cpsr_in,
  input  logic [31:0] exc_pc,
  input  logic [5:0]  req,
  input  logic [3:0]  core_w_addr,
  input  logic [31:0] core_w_data,
  input  logic        core_write_reg,
  input  logic        core_write_pc,
  input  logic [31:0] core_pc_data,
  output logic [4:0]  M,
  output logic [3:0]  w_addr,
  output logic [31:0] w_data,
  output logic        write_reg,
  output logic        write_pc,
  output logic [31:0] pc_data,
  output logic        spsr_we,
  output logic [4:0]  spsr_mode,
  output logic [31:0] spsr_data,
  output logic        cpsr_we,
  output logic [31:0] cpsr_data,
  output logic [5:0]  exc_ack,
  output logic        stall,
  output logic        exc_done
);
  typedef enum logic [2:0] {IDLE, SWITCH, SAVE_LR, VECTOR, DONE} state_t;
  state_t state, state_nx;
  logic [5:0] elig, win, src;
  logic [31:0] old_cpsr, old_pc;
  logic [4:0] mode;
  logic [7:0] voff;
  logic [3:0] loff;
  logic idle;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      src <= '0;
      old_cpsr <= '0;
      old_pc <= '0;
    end else begin
      state <= state_nx;
      if (idle && |win) begin
        src <= win;
        old_cpsr <= cpsr_in;
        old_pc <= exc_pc;
      end
    end
  end
  always_comb begin
    idle = state == IDLE;
    // irq/fiq honour their CPSR masks; an invalid mode (bit 4 clear) blocks everything
    elig = cpsr_in[4] ? {req[5] & ~cpsr_in[6], req[4] & ~cpsr_in[7], req[3:0]} : 6'b0;
    win = elig[3] ? 6'b001000 : elig[5] ? 6'b100000 : elig[4] ? 6'b010000 :
          elig[2] ? 6'b000100 : elig[0] ? 6'b000001 : elig[1] ? 6'b000010 : 6'b000000;
    mode = src[0] ? 5'b11011 : src[1] ? 5'b10011 : (src[2] | src[3]) ? 5'b10111 :
           src[4] ? 5'b10010 : src[5] ? 5'b10001 : 5'b00000;
    voff = src[0] ? 8'h04 : src[1] ? 8'h08 : src[2] ? 8'h0C : src[3] ? 8'h10 :
           src[4] ? 8'h18 : src[5] ? 8'h1C : 8'h00;
    loff = src[3] ? 4'd8 : 4'd4;
    state_nx = idle ? (|win ? SWITCH : IDLE) : state == SWITCH ? SAVE_LR :
               state == SAVE_LR ? VECTOR : state == VECTOR ? DONE : IDLE;
    M = idle ? cpsr_in[4:0] : mode;
    w_addr = idle ? core_w_addr : state == SAVE_LR ? 4'd14 : 4'd0;
    w_data = idle ? core_w_data : state == SAVE_LR ? old_pc + {28'd0, loff} : 32'd0;
    write_reg = idle ? core_write_reg : state == SAVE_LR;
    write_pc = idle ? core_write_pc : state == VECTOR;
    pc_data = idle ? core_pc_data : state == VECTOR ? VBASE + {24'd0, voff} : 32'd0;
    spsr_we = state == SWITCH;
    spsr_mode = spsr_we ? mode : 5'd0;
    spsr_data = spsr_we ? old_cpsr : 32'd0;
    cpsr_we = spsr_we;
    cpsr_data = spsr_we ? {old_cpsr[31:8], 1'b1, old_cpsr[6] | src[5], 1'b0, mode} : 32'd0;
    exc_ack = spsr_we ? src : 6'd0;
    stall = !idle;
    exc_done = state == DONE;
  end
endmodule

// File: tb/tb_exception_sequencer.sv
// tb_exception_sequencer: directed plus random stimulus checked against a queue-based behavioural model
module tb_exception_sequencer;
  logic clk = 0, rst = 1;
  logic [31:0] cpsr_in = 32'h10, exc_pc = 0, core_w_data = 0, core_pc_data = 0;
  logic [5:0] req = 0;
  logic [3:0] core_w_addr = 0;
  logic core_write_reg = 0, core_write_pc = 0;
  logic [4:0] M, spsr_mode;
  logic [3:0] w_addr;
  logic [31:0] w_data, pc_data, spsr_data, cpsr_data;
  logic write_reg, write_pc, spsr_we, cpsr_we, stall, exc_done;
  logic [5:0] exc_ack;
  int checks = 0, errors = 0;
  localparam logic [31:0] VB = 32'h0000_0000;
  exception_sequencer #(.VBASE(VB)) dut (
    .clk(clk), .rst(rst), .cpsr_in(cpsr_in), .exc_pc(exc_pc), .req(req),
    .core_w_addr(core_w_addr), .core_w_data(core_w_data), .core_write_reg(core_write_reg),
    .core_write_pc(core_write_pc), .core_pc_data(core_pc_data), .M(M), .w_addr(w_addr),
    .w_data(w_data), .write_reg(write_reg), .write_pc(write_pc), .pc_data(pc_data),
    .spsr_we(spsr_we), .spsr_mode(spsr_mode), .spsr_data(spsr_data), .cpsr_we(cpsr_we),
    .cpsr_data(cpsr_data), .exc_ack(exc_ack), .stall(stall), .exc_done(exc_done));
  always #5 clk = ~clk;
  typedef struct {
    bit pt;
    logic [4:0] m, smode;
    logic [3:0] wa;
    logic [31:0] wd, pd, sdata, cdata;
    logic wr, wp, swe, cwe, st, done;
    logic [5:0] ack;
  } rec_t;
  rec_t q[$];
  int prio[6] = '{3, 5, 4, 2, 0, 1};
  logic [4:0] mode_tbl[6] = '{5'h1B, 5'h13, 5'h17, 5'h17, 5'h12, 5'h11};
  logic [31:0] voff_tbl[6] = '{32'h04, 32'h08, 32'h0C, 32'h10, 32'h18, 32'h1C};
  logic [31:0] loff_tbl[6] = '{4, 4, 4, 8, 4, 4};
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", n, a, e, $time);
    end
  endtask
  function automatic int pick(input logic [5:0] r, input logic [31:0] c);
    if (!c[4]) return -1;
    foreach (prio[i]) begin
      int k = prio[i];
      if (r[k] && !(k == 4 && c[7]) && !(k == 5 && c[6])) return k;
    end
    return -1;
  endfunction
  function automatic rec_t blank(input logic [4:0] m);
    rec_t r;
    r.pt = 0; r.m = m; r.smode = 0; r.wa = 0; r.wd = 0; r.pd = 0; r.sdata = 0; r.cdata = 0;
    r.wr = 0; r.wp = 0; r.swe = 0; r.cwe = 0; r.st = 1; r.done = 0; r.ack = 0;
    return r;
  endfunction
  task automatic push_seq(input int s, input logic [31:0] c, input logic [31:0] p);
    rec_t r;
    logic [31:0] nc;
    nc = c;
    nc[4:0] = mode_tbl[s];
    nc[7] = 1;
    nc[5] = 0;
    if (s == 5) nc[6] = 1;
    r = blank(mode_tbl[s]); r.swe = 1; r.smode = mode_tbl[s]; r.sdata = c; r.cwe = 1; r.cdata = nc;
    r.ack = 6'(1 << s);
    q.push_back(r);
    r = blank(mode_tbl[s]); r.wr = 1; r.wa = 14; r.wd = p + loff_tbl[s];
    q.push_back(r);
    r = blank(mode_tbl[s]); r.wp = 1; r.pd = VB + voff_tbl[s];
    q.push_back(r);
    r = blank(mode_tbl[s]); r.done = 1;
    q.push_back(r);
  endtask
  task automatic step(input logic r, input logic [5:0] rq, input logic [31:0] cp,
                      input logic [31:0] epc, input logic [3:0] wa, input logic [31:0] wd,
                      input logic wr, input logic wp, input logic [31:0] pd);
    bit was_idle;
    int s;
    rec_t e;
    was_idle = q.size() == 0;
    rst = r; req = rq; cpsr_in = cp; exc_pc = epc;
    core_w_addr = wa; core_w_data = wd; core_write_reg = wr; core_write_pc = wp; core_pc_data = pd;
    if (q.size() != 0) void'(q.pop_front());
    if (r) q.delete();
    else if (was_idle) begin
      s = pick(rq, cp);
      if (s >= 0) push_seq(s, cp, epc);
    end
    @(negedge clk);
    if (q.size() != 0) e = q[0];
    else begin
      e = blank(cpsr_in[4:0]); e.pt = 1; e.st = 0;
      e.wa = core_w_addr; e.wd = core_w_data; e.wr = core_write_reg; e.wp = core_write_pc;
      e.pd = core_pc_data;
    end
    chk("M", M, e.m);
    chk("write_reg", write_reg, e.wr);
    chk("write_pc", write_pc, e.wp);
    chk("spsr_we", spsr_we, e.swe);
    chk("cpsr_we", cpsr_we, e.cwe);
    chk("exc_ack", exc_ack, e.ack);
    chk("stall", stall, e.st);
    chk("exc_done", exc_done, e.done);
    if (e.pt || e.wr) begin
      chk("w_addr", w_addr, e.wa);
      chk("w_data", w_data, e.wd);
    end
    if (e.pt || e.wp) chk("pc_data", pc_data, e.pd);
    if (e.swe) begin
      chk("spsr_mode", spsr_mode, e.smode);
      chk("spsr_data", spsr_data, e.sdata);
    end
    if (e.cwe) chk("cpsr_data", cpsr_data, e.cdata);
  endtask
  task automatic rstep(input logic r, input logic [5:0] rq, input logic [31:0] cp, input logic [31:0] epc);
    step(r, rq, cp, epc, 4'($urandom), $urandom, 1'($urandom), 1'($urandom), $urandom);
  endtask
  initial begin
    logic [8:0] pat;
    logic [31:0] cp;
    repeat (3) rstep(1, 6'b111111, 32'h10, 0);
    chk("reset_stall", stall, 0);
    step(0, 0, 32'h10, 0, 4'd3, 32'hDEAD_BEEF, 1, 0, 0);
    chk("pt_w_addr", w_addr, 3);
    chk("pt_w_data", w_data, 32'hDEAD_BEEF);
    chk("pt_write_reg", write_reg, 1);
    chk("pt_M", M, 5'h10);
    chk("pt_stall", stall, 0);
    rstep(0, 6'b000010, 32'h10, 32'h100);
    chk("svc_spsr_mode", spsr_mode, 5'h13);
    chk("svc_spsr_data", spsr_data, 32'h10);
    chk("svc_cpsr_data", cpsr_data, 32'h93);
    chk("svc_ack", exc_ack, 6'b000010);
    rstep(0, 0, 32'h10, 0);
    chk("svc_lr_addr", w_addr, 14);
    chk("svc_lr_data", w_data, 32'h104);
    chk("svc_lr_M", M, 5'h13);
    rstep(0, 0, 32'h10, 0);
    chk("svc_vector", pc_data, 32'h08);
    rstep(0, 0, 32'h10, 0);
    chk("svc_done", exc_done, 1);
    rstep(0, 0, 32'h10, 0);
    chk("svc_idle_stall", stall, 0);
    rstep(0, 6'b111000, 32'h50, 32'h2000);
    chk("dabt_M", M, 5'h17);
    rstep(0, 0, 32'h10, 0);
    chk("dabt_lr", w_data, 32'h2008);
    rstep(0, 0, 32'h10, 0);
    chk("dabt_vec", pc_data, 32'h10);
    repeat (2) rstep(0, 0, 32'h10, 0);
    rstep(0, 6'b110000, 32'h50, 32'h300);
    chk("irq_ack", exc_ack, 6'b010000);
    repeat (4) rstep(0, 0, 32'h10, 0);
    rstep(0, 6'b110000, 32'hD0, 32'h300);
    chk("masked_stall", stall, 0);
    rstep(0, 6'b100000, 32'h10, 32'h400);
    chk("fiq_cpsr", cpsr_data, 32'hD1);
    repeat (4) step(0, 0, 32'h10, 0, 4'd5, 32'h1234, 1, 1, 32'h5678);
    rstep(0, 6'b000001, 32'h10, 32'h500);
    rstep(0, 0, 32'h10, 0);
    step(1, 0, 32'h10, 0, 4'd7, 32'h77, 1, 0, 0);
    chk("rst_stall", stall, 0);
    chk("rst_write_reg", write_reg, 1);
    chk("rst_no_vector", write_pc, 0);
    rstep(0, 6'b010000, 32'h10, 32'h600);
    pat[8] = stall;
    for (int i = 7; i >= 0; i--) begin
      rstep(0, 6'b010000, 32'h10, 32'h600);
      pat[i] = stall;
    end
    chk("b2b_pattern", 32'(pat), 32'(9'b111101111));
    repeat (3) rstep(1, 0, 32'h10, 0);
    for (int i = 0; i < 600; i++) begin
      cp = $urandom;
      cp[4] = $urandom_range(0, 7) != 0;
      rstep($urandom_range(0, 39) == 0, 6'($urandom & $urandom), cp, $urandom);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/exception_sequencer.md
# exception_sequencer

Sequences ARM-style exception entry onto the banked register file and PC. It sits between the core's writeback stage and the register file write port. It arbitrates pending exception requests by fixed priority and stalls the core. It then drives mode, banked LR, SPSR/CPSR and PC updates over a fixed 4-cycle sequence. When idle it passes core writeback traffic straight through.

## Interface
Parameters:
- VBASE, 32'h0000_0000, exception vector base address.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- cpsr_in  in  32  current CPSR; [4:0] mode, [7] I mask, [6] F mask, [5] T.
- exc_pc  in  32  address of the instruction being interrupted or faulting.
- req  in  6  level exception requests, one-hot index: 0 und, 1 svc, 2 pabt, 3 dabt, 4 irq, 5 fiq.
- core_w_addr  in  4  core writeback register address.
- core_w_data  in  32  core writeback data.
- core_write_reg  in  1  core register write enable.
- core_write_pc  in  1  core PC write enable.
- core_pc_data  in  32  core PC write data.
- M  out  5  mode presented to the register file.
- w_addr  out  4  register file write address.
- w_data  out  32  register file write data.
- write_reg  out  1  register file write enable.
- write_pc  out  1  PC write enable.
- pc_data  out  32  PC write data.
- spsr_we  out  1  SPSR write strobe.
- spsr_mode  out  5  which banked SPSR to write.
- spsr_data  out  32  value to write into that SPSR.
- cpsr_we  out  1  CPSR write strobe.
- cpsr_data  out  32  new CPSR value.
- exc_ack  out  6  one-hot, single-cycle acknowledge of the taken request.
- stall  out  1  core must hold; asserted whenever the state is not IDLE.
- exc_done  out  1  single-cycle pulse at the end of a sequence.

## Operation
- States are IDLE, SWITCH, SAVE_LR, VECTOR and DONE. Encoding is implementer's choice. Reset state is IDLE.
- Eligible requests:
  - req[4] is eligible only if cpsr_in[7]==0.
  - req[5] is eligible only if cpsr_in[6]==0.
  - Other requests are always eligible.
  - No request is eligible if cpsr_in[4]==0 (invalid mode).
- Priority, highest first: dabt, fiq, irq, pabt, und, svc.
- IDLE:
  - Outputs are pure pass-through: M=cpsr_in[4:0], and w_addr, w_data, write_reg, write_pc, pc_data come from the core_* inputs.
  - spsr_we, cpsr_we, exc_ack, stall and exc_done are all 0.
  - If any request is eligible on a posedge, latch the winner, old CPSR and exc_pc, then go to SWITCH.
- Per-source values (mode, vector offset, LR offset):
  - und: 11011, 0x04, +4.
  - svc: 10011, 0x08, +4.
  - pabt: 10111, 0x0C, +4.
  - dabt: 10111, 0x10, +8.
  - irq: 10010, 0x18, +4.
  - fiq: 10001, 0x1C, +4.
- SWITCH:
  - spsr_we=1, spsr_mode=new mode, spsr_data=latched old CPSR.
  - cpsr_we=1, cpsr_data=old CPSR with [4:0]=new mode, [7]=1, [5]=0, and [6]=1 for fiq only (otherwise [6] preserved).
  - exc_ack bit of the winner =1.
  - M=new mode. Next state: SAVE_LR.
- SAVE_LR: M=new mode, write_reg=1, w_addr=14, w_data=latched exc_pc+LR offset, modulo 2^32. Next state: VECTOR.
- VECTOR: M=new mode, write_pc=1, pc_data=VBASE+vector offset, modulo 2^32. Next state: DONE.
- DONE: M=new mode, exc_done=1, no write strobes. Next state: IDLE.
- In all non-IDLE states the core_* inputs are ignored and must not reach the register file. Only the strobe named for each state is 1.

## Timing
- All outputs except the IDLE pass-through path are registered.
- The IDLE pass-through is combinational from the core_* inputs and cpsr_in.
- Outputs are stable from posedge through the following negedge, since the register file writes on negedge.
- Latency: request sampled at edge N. SWITCH occupies cycle N+1, SAVE_LR N+2, VECTOR N+3, DONE N+4, back in IDLE at N+5.
- stall is high for exactly 4 cycles per exception.
- Back-to-back exceptions: a request still eligible in the IDLE cycle after DONE is taken at that edge. Minimum gap is 1 IDLE cycle. That IDLE cycle passes core writes through.
- Requests are sampled only in IDLE. Changes on req or cpsr_in during a sequence have no effect.
- A requester holds req until its exc_ack. Dropping req before ack when not yet taken loses the request; this is legal.
- The winner is fixed at the IDLE sample edge. A higher-priority request arriving later waits for the next IDLE.
- rst=1 at any edge, including mid-sequence: next state IDLE, all strobes, exc_ack, exc_done and stall 0. Latched registers are cleared to 0. No partial sequence is resumed.

## Test plan
- Pass-through: idle, no req, core_write_reg=1, core_w_addr=3, core_w_data=0xDEAD_BEEF, cpsr_in=0x10 -> w_addr=3, w_data=0xDEAD_BEEF, write_reg=1, M=0x10, stall=0.
- SVC entry: cpsr_in=0x0000_0010, exc_pc=0x100, req=6'b000010 -> the following, then exc_done and return to IDLE:
  - SWITCH: spsr_mode=0x13, spsr_data=0x10, cpsr_data=0x93, exc_ack=000010.
  - SAVE_LR: w_addr=14, w_data=0x104, M=0x13.
  - VECTOR: pc_data=0x08.
- Priority and masking:
  - req=6'b111000 with cpsr_in I=0, F=0 -> dabt taken; mode 0x17, LR=exc_pc+8, vector 0x10.
  - Same stimulus with cpsr_in F=1 -> still dabt.
  - req=6'b110000 with F=1, I=0 -> irq taken (fiq masked).
  - req=6'b110000 with F=1, I=1 -> no sequence.
- FIQ CPSR: cpsr_in=0x10, req[5]=1 -> cpsr_data=0xD1. Core writes presented during stall never appear on write_reg or write_pc.
- Reset mid-sequence: assert rst during SAVE_LR -> next cycle IDLE, stall=0, write_reg follows core_write_reg, no VECTOR write issued.
- Back-to-back: irq held through DONE -> one IDLE cycle, then a new SWITCH; stall pattern 1111 0 1111.
